// File: rtl/mc_controller.sv
// mc_controller: multicycle sequencing controller for the ARM-subset datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback,
// drives every datapath mux and write enable, and holds the NZCV flags.
// Optional feature macro: CTRL_MEM_WAIT_EN (FETCH, MEMREAD and MEMWRITE
// stretch until MemReady). Without it MemReady is ignored.
// Outputs are a combinational decode of the registered state so the FETCH
// controls are valid in the very first cycle after reset releases.
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  Flags,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     r_state;
    logic [3:0] r_flags;   // {N, Z, C, V}

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic       w_rd_pc;
    logic       w_cond_ex;
    logic [1:0] w_alu_dp;
    logic       w_cmd_arith;
    logic       w_mem_ok;
    logic       w_unused;

    assign w_cond  = Instr[31:28];
    assign w_op    = Instr[27:26];
    assign w_funct = Instr[25:20];
    assign w_rd_pc = (Instr[15:12] == 4'hF);
    assign w_unused = ^{Instr[19:16], Instr[11:0], MemReady};

`ifdef CTRL_MEM_WAIT_EN
    assign w_mem_ok = MemReady;
`else
    assign w_mem_ok = 1'b1;
`endif

    // Condition evaluation against the registered flags
    always_comb begin
        w_cond_ex = 1'b0;
        case (w_cond)
            4'b0000: w_cond_ex = r_flags[2];
            4'b0001: w_cond_ex = ~r_flags[2];
            4'b0010: w_cond_ex = r_flags[1];
            4'b0011: w_cond_ex = ~r_flags[1];
            4'b0100: w_cond_ex = r_flags[3];
            4'b0101: w_cond_ex = ~r_flags[3];
            4'b0110: w_cond_ex = r_flags[0];
            4'b0111: w_cond_ex = ~r_flags[0];
            4'b1000: w_cond_ex = r_flags[1] & ~r_flags[2];
            4'b1001: w_cond_ex = ~r_flags[1] | r_flags[2];
            4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
            4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
            4'b1100: w_cond_ex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'b1101: w_cond_ex = r_flags[2] | (r_flags[3] != r_flags[0]);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // Data-processing command decode; unknown commands fall back to ADD
    always_comb begin
        w_alu_dp = 2'b00;
        case (w_funct[4:1])
            4'b0100: w_alu_dp = 2'b00;
            4'b0010: w_alu_dp = 2'b01;
            4'b0000: w_alu_dp = 2'b10;
            4'b1100: w_alu_dp = 2'b11;
            default: w_alu_dp = 2'b00;
        endcase
    end

    // C and V only carry meaning for the arithmetic ops (decoded ADD/SUB)
    assign w_cmd_arith = ~w_alu_dp[1];

    // State register and flag register; flags update on the execute edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_flags <= 4'b0000;
        end else begin
            case (r_state)
                S_FETCH:    if (w_mem_ok) r_state <= S_DECODE;
                S_DECODE: begin
                    case (w_op)
                        2'b00:   r_state <= w_funct[5] ? S_EXECI : S_EXECR;
                        2'b01:   r_state <= S_MEMADR;
                        2'b10:   r_state <= S_BRANCH;
                        default: r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   r_state <= w_funct[0] ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (w_mem_ok) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: if (w_mem_ok) r_state <= S_FETCH;
                S_EXECR, S_EXECI: begin
                    r_state <= S_ALUWB;
                    if (w_funct[0] & w_cond_ex) begin
                        r_flags[3:2] <= ALUFlags[3:2];
                        if (w_cmd_arith) r_flags[1:0] <= ALUFlags[1:0];
                    end
                end
                S_ALUWB:    r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Per-state datapath controls; write enables are blocked while in reset
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        case (r_state)
            S_FETCH: begin
                IRWrite   = w_mem_ok;
                PCWrite   = w_mem_ok;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = w_cond_ex & ~w_rd_pc;
                PCWrite   = w_cond_ex & w_rd_pc;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = w_cond_ex;
            end
            S_EXECR:    ALUControl = w_alu_dp;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_dp;
            end
            S_ALUWB: begin
                RegWrite = w_cond_ex & ~w_rd_pc;
                PCWrite  = w_cond_ex & w_rd_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = w_cond_ex;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    // Immediate/register-source selects follow the op class directly
    always_comb begin
        ImmSrc = 2'b00;
        RegSrc = 2'b00;
        case (w_op)
            2'b01: begin ImmSrc = 2'b01; RegSrc = 2'b10; end
            2'b10: begin ImmSrc = 2'b10; RegSrc = 2'b01; end
            default: ;
        endcase
    end

    assign Flags = r_flags;
    assign State = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: each instruction is held on Instr for its
// whole sequence, the state trace and controls are captured per cycle at
// mid-cycle, and then compared against hand-derived values.
module tb_mc_controller;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0]  Flags, State;

    int n_total = 0;
    int n_bad   = 0;

    // per-cycle capture of the last instruction run
    logic       c_pcw [8];
    logic       c_irw [8];
    logic       c_rw  [8];
    logic       c_mw  [8];
    logic       c_adr [8];
    logic       c_srca[8];
    logic [1:0] c_srcb[8];
    logic [1:0] c_rsrc[8];
    logic [1:0] c_aluc[8];
    logic [1:0] c_imm [8];
    logic [1:0] c_reg [8];
    int n_rw, n_pw, n_mw, n_irw;

    mc_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Flags(Flags), .State(State)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; runs n cycles, checking the state trace
    // (nibbles of seq, first state in the low nibble) and capturing controls.
    task automatic run(input string nm, input logic [31:0] ins, input logic [3:0] af,
                       input int n, input logic [31:0] seq);
        Instr    = ins;
        ALUFlags = af;
        n_rw = 0; n_pw = 0; n_mw = 0; n_irw = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk({nm, ".state"}, State, seq[4*i +: 4]);
            c_pcw[i]  = PCWrite;   c_irw[i]  = IRWrite;
            c_rw[i]   = RegWrite;  c_mw[i]   = MemWrite;
            c_adr[i]  = AdrSrc;    c_srca[i] = ALUSrcA;
            c_srcb[i] = ALUSrcB;   c_rsrc[i] = ResultSrc;
            c_aluc[i] = ALUControl;
            c_imm[i]  = ImmSrc;    c_reg[i]  = RegSrc;
            n_rw  += int'(RegWrite);
            n_pw  += int'(PCWrite);
            n_mw  += int'(MemWrite);
            n_irw += int'(IRWrite);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; Instr = 32'h0; ALUFlags = 4'h0; MemReady = 1'b1;
        #1;
        chk("rst.state", State, 4'd0);
        chk("rst.flags", Flags, 4'h0);
        chk("rst.we", {PCWrite, IRWrite, RegWrite, MemWrite}, 4'b0000);
        chk("rst.mux", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, 6'b0_1_10_10);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ADD R2,R0,#5
        run("add", 32'hE2802005, 4'h0, 4, 32'h8710);
        chk("add.fetch", {c_irw[0], c_pcw[0], c_adr[0], c_srca[0], c_srcb[0], c_rsrc[0]}, 8'hDA);
        chk("add.dec", {c_pcw[1], c_irw[1], c_srca[1], c_srcb[1], c_rsrc[1]}, 7'b0_0_1_10_10);
        chk("add.exb", c_srcb[2], 2'b01);
        chk("add.exa", c_srca[2], 1'b0);
        chk("add.alu", c_aluc[2], 2'b00);
        chk("add.rwwb", c_rw[3], 1'b1);
        chk("add.rwcnt", n_rw, 1);
        chk("add.rsrc", c_rsrc[3], 2'b00);
        chk("add.imm", {c_imm[0], c_reg[0]}, 4'b0000);

        // SUBS R3,R2,R2 with ALU reporting Z
        run("subs", 32'hE0523002, 4'b0100, 4, 32'h8610);
        chk("subs.alu", c_aluc[2], 2'b01);
        chk("subs.exb", c_srcb[2], 2'b00);
        chk("subs.flags", Flags, 4'b0100);

        // BEQ taken, BNE not taken
        run("beq", 32'h0A000001, 4'h0, 3, 32'h910);
        chk("beq.pcw", c_pcw[2], 1'b1);
        chk("beq.mux", {c_srca[2], c_srcb[2], c_rsrc[2]}, 5'b0_01_10);
        chk("beq.imm", {c_imm[0], c_reg[0]}, 4'b1001);
        run("bne", 32'h1A000001, 4'h0, 3, 32'h910);
        chk("bne.pcw", c_pcw[2], 1'b0);

        // LDR R1,[R0,#4]
        run("ldr", 32'hE5901004, 4'h0, 5, 32'h43210);
        chk("ldr.adr", c_adr[3], 1'b1);
        chk("ldr.madr", {c_srca[2], c_srcb[2], c_aluc[2]}, 5'b0_01_00);
        chk("ldr.rsrc", c_rsrc[4], 2'b01);
        chk("ldr.rw", c_rw[4], 1'b1);
        chk("ldr.rwcnt", n_rw, 1);
        chk("ldr.imm", {c_imm[0], c_reg[0]}, 4'b0110);

        // STR R1,[R0,#4]
        run("str", 32'hE5801004, 4'h0, 4, 32'h5210);
        chk("str.mw", c_mw[3], 1'b1);
        chk("str.mwcnt", n_mw, 1);
        chk("str.rwcnt", n_rw, 0);
        chk("str.adr", c_adr[3], 1'b1);

        // ANDS: N,Z load, C,V keep old value
        run("ands", 32'hE0112002, 4'b1011, 4, 32'h8610);
        chk("ands.alu", c_aluc[2], 2'b10);
        chk("ands.flags", Flags, 4'b1000);

        // ORR and an unsupported command (decodes as ADD)
        run("orr", 32'hE1812002, 4'b0111, 4, 32'h8610);
        chk("orr.alu", c_aluc[2], 2'b11);
        chk("orr.flags", Flags, 4'b1000);
        run("eor", 32'hE0212002, 4'h0, 4, 32'h8610);
        chk("eor.alu", c_aluc[2], 2'b00);

        // cond 1111 never executes
        run("nv", 32'hF2802005, 4'hF, 4, 32'h8710);
        chk("nv.rw", c_rw[3], 1'b0);
        chk("nv.flags", Flags, 4'b1000);

        // EQ SUBS with Z clear: no flag update, no register write
        run("eqs", 32'h00523002, 4'b0111, 4, 32'h8610);
        chk("eqs.rw", n_rw, 0);
        chk("eqs.flags", Flags, 4'b1000);

        // ADD to R15 writes PC, not register file
        run("addpc", 32'hE280F005, 4'h0, 4, 32'h8710);
        chk("addpc.rw", c_rw[3], 1'b0);
        chk("addpc.pw", c_pcw[3], 1'b1);

        // op 11 returns to fetch after decode
        run("op3", 32'hEC000000, 4'h0, 2, 32'h10);
        // BMI taken (N set)
        run("bmi", 32'h4A000001, 4'h0, 3, 32'h910);
        chk("bmi.pcw", c_pcw[2], 1'b1);

        // reset in the middle of an LDR
        run("ldr2", 32'hE5901004, 4'h0, 3, 32'h210);
        #1;
        chk("mid.pre", State, 4'd3);
        reset = 1'b1;
        #1;
        chk("mid.state", State, 4'd0);
        chk("mid.flags", Flags, 4'h0);
        chk("mid.we", {PCWrite, IRWrite, RegWrite, MemWrite}, 4'b0000);
        @(negedge clk);
        chk("mid.hold", State, 4'd0);
        reset = 1'b0;

`ifdef CTRL_MEM_WAIT_EN
        // fetch stretched by three not-ready cycles
        MemReady = 1'b0;
        run("wait", 32'hE2802005, 4'h0, 3, 32'h000);
        chk("wait.irw0", n_irw, 0);
        chk("wait.pw0", n_pw, 0);
        MemReady = 1'b1;
        #1;
        chk("wait.st", State, 4'd0);
        chk("wait.irw", IRWrite, 1'b1);
        @(negedge clk);
        #1;
        chk("wait.dec", State, 4'd1);
`else
        // MemReady has no effect when waits are compiled out
        MemReady = 1'b0;
        run("nowait", 32'hE2802005, 4'h0, 4, 32'h8710);
        chk("nowait.irw", n_irw, 1);
        chk("nowait.rw", n_rw, 1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle sequencing controller for the ARM-subset processor datapath. It walks each instruction through fetch, decode, execute, memory and writeback states and drives every datapath mux and write enable. It evaluates the condition field against an internal NZCV flag register and suppresses architectural writes when the condition fails. It sits between instruction/ALU-flag sources and the shared-memory multicycle datapath inside `microProcessor`.

## Interface
No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- Instr  in  32  current instruction register contents; only [31:12] used
- ALUFlags  in  4  {Negative, Zero, Carry, Overflow} from the datapath ALU, current cycle
- MemReady  in  1  memory access complete (used only with CTRL_MEM_WAIT_EN)
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write enables
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 = register B, 01 = extended immediate, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALU result
- ImmSrc, RegSrc  out  2 each  decoded from op (DP: 00/00, MEM: 01/10, B: 10/01)
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- Flags  out  4  registered NZCV
- State  out  4  current state code (debug)

## Operation
- Fields: cond = Instr[31:28], op = Instr[27:26], funct = Instr[25:20], Rd = Instr[15:12].
- DP cmd funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; any other cmd decodes as ADD. S = funct[0]. MEM: L = funct[0], offset always added.
- CondEx from registered Flags: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
- States/codes and outputs; unlisted outputs are 0:
  - FETCH 0: AdrSrc 0, IRWrite 1, ALUSrcA 1, ALUSrcB 10, ADD, ResultSrc 10, PCWrite 1 → DECODE.
  - DECODE 1: ALUSrcA 1, ALUSrcB 10, ADD, ResultSrc 10. Transitions: op 00 with funct[5]=1 → EXECUTEI, otherwise → EXECUTER; op 01 → MEMADR; op 10 → BRANCH; op 11 → FETCH.
  - MEMADR 2: ALUSrcA 0, ALUSrcB 01, ADD. L=1 → MEMREAD; L=0 → MEMWRITE.
  - MEMREAD 3: AdrSrc 1 → MEMWB.
  - MEMWB 4: ResultSrc 01, RegWrite = CondEx & (Rd≠15), PCWrite = CondEx & (Rd=15) → FETCH.
  - MEMWRITE 5: AdrSrc 1, MemWrite = CondEx → FETCH.
  - EXECUTER 6: ALUSrcA 0, ALUSrcB 00, decoded cmd → ALUWB.
  - EXECUTEI 7: same as EXECUTER, but ALUSrcB 01 → ALUWB.
  - ALUWB 8: ResultSrc 00, RegWrite/PCWrite as in MEMWB → FETCH.
  - BRANCH 9: ALUSrcA 0, ALUSrcB 01, ADD, ResultSrc 10, PCWrite = CondEx → FETCH.
- Flag update happens at the EXECUTER/EXECUTEI clock edge, only when S & CondEx:
  - N and Z always load from ALUFlags.
  - C and V load only when cmd is ADD or SUB.
- Unused state codes (10–15) → FETCH.

## Timing
- Latency: DP 4 cycles; LDR 5; STR 4; B 3; op 11 takes 2 cycles.
- Reset (async):
  - State = FETCH, Flags = 0000.
  - While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0; the mux outputs show FETCH values.
  - First fetch completes on the first rising edge after reset deasserts.
- Reset mid-instruction abandons the instruction: no further writes, Flags cleared.
- CondEx is combinational from registered Flags and Instr.

## Configuration
- `CTRL_MEM_WAIT_EN` defined:
  - FETCH, MEMREAD and MEMWRITE hold while MemReady = 0.
  - In FETCH, PCWrite and IRWrite assert only in the cycle where MemReady = 1.
  - MemWrite stays asserted for every MEMWRITE cycle.
- Not defined: MemReady is ignored and every state lasts exactly one cycle.

## Test plan
- Reset, then Instr = 0xE2802005 (ADD R2,R0,#5):
  - State sequence 0,1,7,8,0.
  - ALUSrcB = 01 and ALUControl = 00 in state 7.
  - RegWrite = 1 only in ALUWB.
- 0xE0523002 (SUBS R3,R2,R2) with ALUFlags = 0100 in EXECUTER → Flags = 0100. Then:
  - 0x0A000001 (BEQ): PCWrite = 1 in BRANCH.
  - 0x1A000001 (BNE): PCWrite = 0 in BRANCH.
- 0xE5901004 (LDR R1,[R0,#4]):
  - States 0,1,2,3,4 with AdrSrc = 1 in state 3.
  - ResultSrc = 01 and RegWrite = 1 in MEMWB.
- 0xE5801004 (STR): MemWrite = 1 for exactly one cycle (state 5); RegWrite is never asserted.
- 0xF2802005 (cond 1111): RegWrite = 0 in ALUWB and Flags unchanged. Assert reset during MEMREAD → State = 0 immediately, Flags = 0000, no write enables asserted.
- With `CTRL_MEM_WAIT_EN`, MemReady held low for 3 cycles in FETCH → State stays 0 for 4 cycles and IRWrite pulses once.
